// File: rtl/day_of_year_seq.sv
// Sequential day-of-year calculator: checks a (month, day, leap) request when it is
// accepted, then adds one month length per cycle through a single shared adder.
module day_of_year_seq #(
    parameter bit LEAP_EN = 1'b1  // 0: February is always 28 days
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       start_valid_i,
    output logic       start_ready_o,
    input  logic [3:0] month_i,
    input  logic [5:0] day_of_month_i,
    input  logic       leap_year_i,
    output logic       result_valid_o,
    input  logic       result_ready_i,
    output logic [8:0] day_of_year_o,
    output logic       error_o,
    output logic [1:0] err_code_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [1:0] ErrNone  = 2'b00;
    localparam logic [1:0] ErrMonth = 2'b01;
    localparam logic [1:0] ErrDay   = 2'b10;

    logic [1:0] state_q, state_d;
    logic [8:0] acc_q, acc_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] month_q, month_d;
    logic       leap_q, leap_d;
    logic [8:0] doy_q, doy_d;
    logic       error_q, error_d;
    logic [1:0] err_code_q, err_code_d;

    function automatic logic [8:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      month_len = (LEAP_EN && leap) ? 9'd29 : 9'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   month_len = 9'd30;
            default:                   month_len = 9'd31;
        endcase
    endfunction

    // Next-state: validate at the start handshake, accumulate in ACCUM, hold in DONE.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        month_d    = month_q;
        leap_d     = leap_q;
        doy_d      = doy_q;
        error_d    = error_q;
        err_code_d = err_code_q;

        case (state_q)
            StIdle: begin
                if (start_valid_i) begin
                    month_d    = month_i;
                    leap_d     = leap_year_i;
                    doy_d      = 9'd0;
                    error_d    = 1'b0;
                    err_code_d = ErrNone;
                    if (month_i == 4'd0 || month_i > 4'd12) begin
                        state_d    = StDone;
                        error_d    = 1'b1;
                        err_code_d = ErrMonth;
                    end else if (day_of_month_i == 6'd0 ||
                                 {3'd0, day_of_month_i} > month_len(month_i, leap_year_i)) begin
                        state_d    = StDone;
                        error_d    = 1'b1;
                        err_code_d = ErrDay;
                    end else begin
                        acc_d = {3'd0, day_of_month_i};
                        idx_d = 4'd1;
                        if (month_i == 4'd1) begin
                            state_d = StDone;
                            doy_d   = {3'd0, day_of_month_i};
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
            end
            StAccum: begin
                acc_d = acc_q + month_len(idx_q, leap_q);
                idx_d = idx_q + 4'd1;
                // Last full month before the requested one has just been added.
                if (idx_d == month_q) begin
                    state_d = StDone;
                    doy_d   = acc_d;
                end
            end
            StDone: begin
                if (result_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides any handshake in the same cycle.
        if (clear_i) begin
            state_d    = StIdle;
            doy_d      = 9'd0;
            error_d    = 1'b0;
            err_code_d = ErrNone;
        end
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= 9'd0;
            idx_q      <= 4'd0;
            month_q    <= 4'd0;
            leap_q     <= 1'b0;
            doy_q      <= 9'd0;
            error_q    <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            month_q    <= month_d;
            leap_q     <= leap_d;
            doy_q      <= doy_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign start_ready_o  = (state_q == StIdle);
    assign result_valid_o = (state_q == StDone);
    assign day_of_year_o  = doy_q;
    assign error_o        = error_q;
    assign err_code_o     = err_code_q;

endmodule

// File: tb/tb_day_of_year_seq.sv
// Bench for day_of_year_seq: directed spec cases plus randomized requests against
// a calendar model; a second instance with LEAP_EN=0 shares all inputs.
module tb_day_of_year_seq;

    logic       clk = 1'b0;
    logic       run_clk = 1'b1;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       start_valid = 1'b0;
    logic [3:0] month = 4'd0;
    logic [5:0] dom = 6'd0;
    logic       leap = 1'b0;
    logic       result_ready = 1'b1;

    logic       start_ready, result_valid, error;
    logic [8:0] doy;
    logic [1:0] err_code;
    logic       nl_start_ready, nl_result_valid, nl_error;
    logic [8:0] nl_doy;
    logic [1:0] nl_err_code;

    int tests = 0;
    int fails = 0;
    int nl_code_seen;

    always #5 if (run_clk) clk = ~clk;

    day_of_year_seq #(.LEAP_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear),
        .start_valid_i(start_valid), .start_ready_o(start_ready),
        .month_i(month), .day_of_month_i(dom), .leap_year_i(leap),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .day_of_year_o(doy), .error_o(error), .err_code_o(err_code)
    );

    day_of_year_seq #(.LEAP_EN(1'b0)) u_noleap (
        .clk(clk), .rst_n(rst_n), .clear_i(clear),
        .start_valid_i(start_valid), .start_ready_o(nl_start_ready),
        .month_i(month), .day_of_month_i(dom), .leap_year_i(leap),
        .result_valid_o(nl_result_valid), .result_ready_i(result_ready),
        .day_of_year_o(nl_doy), .error_o(nl_error), .err_code_o(nl_err_code)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Calendar reference: plain table lookup and summation.
    function automatic int days_in(input int m, input bit lp, input bit en);
        int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && en && lp) return 29;
        return tbl[m-1];
    endfunction

    task automatic model(input int m, input int d, input bit lp, input bit en,
                         output int exp_doy, output int exp_code, output int exp_lat);
        exp_doy = 0;
        exp_lat = 1;
        if (m < 1 || m > 12) begin
            exp_code = 1;
        end else if (d < 1 || d > days_in(m, lp, en)) begin
            exp_code = 2;
        end else begin
            exp_code = 0;
            exp_doy  = d;
            for (int k = 1; k < m; k++) exp_doy += days_in(k, lp, en);
            exp_lat = m;
        end
    endtask

    // Issue one request (called #1 after a rising edge) and check the result.
    // Inputs are scrambled after the handshake to confirm they were latched.
    task automatic req(input string tag, input int m, input int d, input bit lp,
                       input int exp_doy, input int exp_code, input int exp_lat);
        int lat;
        check({tag, ".ready"}, int'(start_ready), 1);
        month = 4'(m); dom = 6'(d); leap = lp; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        month = 4'($urandom); dom = 6'($urandom); leap = 1'($urandom);
        nl_code_seen = nl_result_valid ? int'(nl_err_code) : -1;
        lat = 1;
        while (!result_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},  lat, exp_lat);
        check({tag, ".doy"},  int'(doy), exp_doy);
        check({tag, ".err"},  int'(error), int'(exp_code != 0));
        check({tag, ".code"}, int'(err_code), exp_code);
        // With result_ready high the result handshake consumes the next edge.
        if (result_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int e_doy, e_code, e_lat, rose, m, d;
        bit lp;

        // Reset state, visible before any clock edge.
        #1;
        check("rst.ready", int'(start_ready), 1);
        check("rst.valid", int'(result_valid), 0);
        check("rst.doy", int'(doy), 0);
        check("rst.code", int'(err_code), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        req("feb1", 2, 1, 0, 32, 0, 2);
        req("dec31", 12, 31, 0, 365, 0, 12);
        req("dec31_leap", 12, 31, 1, 366, 0, 12);
        req("jan1", 1, 1, 0, 1, 0, 1);
        req("feb29", 2, 29, 0, 0, 2, 1);
        req("feb29_leap", 2, 29, 1, 60, 0, 2);
        check("noleap.feb29.code", nl_code_seen, 2);
        req("apr31", 4, 31, 0, 0, 2, 1);
        req("day0", 5, 0, 0, 0, 2, 1);
        req("month0", 0, 10, 0, 0, 1, 1);
        req("month13", 13, 40, 0, 0, 1, 1);

        // Backpressure: hold result for 5 cycles, stray start pulse ignored.
        result_ready = 1'b0;
        req("jul4", 7, 4, 0, 185, 0, 7);
        for (int i = 0; i < 5; i++) begin
            start_valid = (i == 2);
            month = 4'd1; dom = 6'd1;
            @(posedge clk); #1;
            check("bp.doy", int'(doy), 185);
            check("bp.ready", int'(start_ready), 0);
            check("bp.valid", int'(result_valid), 1);
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release.valid", int'(result_valid), 0);
        check("bp.release.ready", int'(start_ready), 1);
        req("after_bp", 3, 15, 0, 74, 0, 3);

        // Abort during ACCUM.
        month = 4'd12; dom = 6'd31; leap = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr.ready", int'(start_ready), 1);
        check("clr.doy", int'(doy), 0);
        check("clr.err", int'(error), 0);
        rose = 0;
        repeat (15) begin @(posedge clk); #1; if (result_valid) rose = 1; end
        check("clr.no_result", rose, 0);

        // Clear together with a start in IDLE: request dropped.
        month = 4'd2; dom = 6'd1; start_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; clear = 1'b0;
        check("clr_start.ready", int'(start_ready), 1);
        rose = 0;
        repeat (15) begin @(posedge clk); #1; if (result_valid) rose = 1; end
        check("clr_start.no_result", rose, 0);

        // Asynchronous reset mid-ACCUM with the clock stopped.
        month = 4'd12; dom = 6'd31; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        run_clk = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst.valid", int'(result_valid), 0);
        check("arst.ready", int'(start_ready), 1);
        check("arst.doy", int'(doy), 0);
        #2 rst_n = 1'b1;
        #2 run_clk = 1'b1;
        @(posedge clk); #1;
        req("mar1_leap", 3, 1, 1, 61, 0, 3);

        // Randomized requests, including out-of-range month and day.
        for (int i = 0; i < 60; i++) begin
            m  = int'($urandom_range(0, 14));
            d  = int'($urandom_range(0, 33));
            lp = 1'($urandom);
            model(m, d, lp, 1'b1, e_doy, e_code, e_lat);
            req($sformatf("rand%0d", i), m, d, lp, e_doy, e_code, e_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed hang expected completion");
        $fatal(1, "timeout");
    end

endmodule
